// File: rtl/seq_detector_display.sv
// seq_detector_display: serial pattern detector with a BCD match counter and a
// multiplexed four-digit seven-segment driver, all on one clock.
module seq_detector_display #(
  parameter int                 SEQ_LEN  = 4,
  parameter logic [SEQ_LEN-1:0] PATTERN  = 4'b1011,
  parameter bit                 OVERLAP  = 1'b1,
  parameter int                 SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  input  logic        din_valid,
  input  logic        clr_cnt,
  output logic        match,
  output logic [15:0] match_count,
  output logic [6:0]  seven_seg,
  output logic [3:0]  seven_enable
);

  localparam int                FILL_W    = $clog2(SEQ_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_LEN);
  localparam int                SCAN_W    = $clog2(SCAN_DIV);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  // BCD increment of the four-digit count; 9999 wraps to 0000.
  function automatic logic [15:0] bcd_inc(input logic [15:0] value);
    logic [15:0] result;
    logic        carry;
    result = value;
    carry  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (value[4*i +: 4] == 4'd9) begin
          result[4*i +: 4] = 4'd0;
        end else begin
          result[4*i +: 4] = value[4*i +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
    return result;
  endfunction

  // Active-low segment pattern {G..A}; non-BCD nibbles blank the digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  logic [SEQ_LEN-1:0] history;
  logic [FILL_W-1:0]  fill;
  logic [SEQ_LEN:0]   shifted;
  logic [SEQ_LEN-1:0] history_next;
  logic [FILL_W-1:0]  fill_next;
  logic               hit;

  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         digit;
  logic [1:0]         digit_next;

  // Next history/fill for an accepted bit and whether it completes the pattern.
  always_comb begin
    shifted      = {history, din};
    history_next = shifted[SEQ_LEN-1:0];
    fill_next    = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
    hit          = (history_next == PATTERN) && (fill_next == FILL_FULL);
    digit_next   = digit + 2'd1;
  end

  // Detector: shift in accepted bits, pulse match, restart fill when non-overlapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      history <= '0;
      fill    <= '0;
      match   <= 1'b0;
    end else if (din_valid) begin
      history <= history_next;
      fill    <= (hit && !OVERLAP) ? '0 : fill_next;
      match   <= hit;
    end else begin
      match   <= 1'b0;
    end
  end

  // Match counter: clear has priority over the increment from a match pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_count <= 16'h0000;
    end else if (clr_cnt) begin
      match_count <= 16'h0000;
    end else if (match) begin
      match_count <= bcd_inc(match_count);
    end
  end

  // Display scan: enable and segments advance together on the terminal count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt     <= '0;
      digit        <= 2'd0;
      seven_enable <= 4'b1110;
      seven_seg    <= 7'b1000000;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt     <= '0;
      digit        <= digit_next;
      seven_enable <= ~(4'b0001 << digit_next);
      seven_seg    <= seg_decode(match_count[{digit_next, 2'b00} +: 4]);
    end else begin
      scan_cnt     <= scan_cnt + SCAN_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detector_display.sv
// Bench for seq_detector_display: three configurations share one stimulus
// stream; a queue-based scoreboard is checked by an independent monitor.
module tb_seq_detector_display;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic clr_cnt = 1'b0;

  logic        a_match, b_match, c_match;
  logic [15:0] a_cnt, b_cnt, c_cnt;
  logic [6:0]  a_seg, b_seg, c_seg;
  logic [3:0]  a_en, b_en, c_en;

  always #5 clk = ~clk;

  seq_detector_display #(.SEQ_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .SCAN_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
    .match(a_match), .match_count(a_cnt), .seven_seg(a_seg), .seven_enable(a_en));

  seq_detector_display #(.SEQ_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .SCAN_DIV(4)) dut_b (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
    .match(b_match), .match_count(b_cnt), .seven_seg(b_seg), .seven_enable(b_en));

  seq_detector_display #(.SEQ_LEN(1), .PATTERN(1'b1), .OVERLAP(1'b1), .SCAN_DIV(4)) dut_c (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
    .match(c_match), .match_count(c_cnt), .seven_seg(c_seg), .seven_enable(c_en));

  typedef bit bitq_t[$];

  typedef struct {
    logic        a_m;
    logic [15:0] a_c;
    logic [3:0]  a_en;
    logic [6:0]  a_seg;
    logic        b_m;
    logic [15:0] b_c;
    logic        c_m;
    logic [15:0] c_c;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [6:0] glyph [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  // Reference model state
  bitq_t      qa, qb, qc;
  bit         ma, mb, mc;
  int         ca, cb, cc;
  int         scan, idx;
  logic [3:0] en_m;
  logic [6:0] seg_m;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  // Keeps the last L accepted bits; a match is the last L bits reading as pat.
  task automatic det_step(inout bitq_t q, input int len, input int pat, input bit ovl,
                          input bit d, output bit m);
    int v;
    q.push_back(d);
    if (q.size() > len) void'(q.pop_front());
    m = 1'b0;
    if (q.size() == len) begin
      v = 0;
      foreach (q[i]) v = v * 2 + int'(q[i]);
      if (v == pat) begin
        m = 1'b1;
        if (!ovl) q.delete();
      end
    end
  endtask

  task automatic model_reset();
    qa.delete(); qb.delete(); qc.delete();
    ma = 0; mb = 0; mc = 0;
    ca = 0; cb = 0; cc = 0;
    scan = 0; idx = 0;
    en_m = 4'b1110;
    seg_m = glyph[0];
  endtask

  task automatic model_edge(input bit d, input bit v, input bit c);
    int p10;
    if (scan == 3) begin
      scan = 0;
      idx = (idx + 1) % 4;
      en_m = ~(4'b0001 << idx);
      p10 = 1;
      for (int k = 0; k < idx; k++) p10 = p10 * 10;
      seg_m = glyph[(ca / p10) % 10];
    end else begin
      scan++;
    end
    if (c) begin
      ca = 0; cb = 0; cc = 0;
    end else begin
      if (ma) ca = (ca + 1) % 10000;
      if (mb) cb = (cb + 1) % 10000;
      if (mc) cc = (cc + 1) % 10000;
    end
    if (v) begin
      det_step(qa, 4, 11, 1'b1, d, ma);
      det_step(qb, 4, 11, 1'b0, d, mb);
      det_step(qc, 1, 1, 1'b1, d, mc);
    end else begin
      ma = 0; mb = 0; mc = 0;
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.a_m = ma; e.a_c = to_bcd(ca); e.a_en = en_m; e.a_seg = seg_m;
    e.b_m = mb; e.b_c = to_bcd(cb);
    e.c_m = mc; e.c_c = to_bcd(cc);
    sb.push_back(e);
  endtask

  // Called at posedge+1: drive inputs, advance model at the edge, queue expectation.
  task automatic cycle(input bit d, input bit v, input bit c, input bit r);
    if (!r) begin
      sb.delete();
      model_reset();
    end
    din = d; din_valid = v; clr_cnt = c; rst = r;
    @(posedge clk);
    if (r) model_edge(d, v, c);
    else model_reset();
    push_expected();
    #1;
  endtask

  // Monitor: compare the DUT outputs against the oldest expectation each cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("a_match", 16'(a_match), 16'(e.a_m));
      check("a_count", a_cnt, e.a_c);
      check("a_enable", 16'(a_en), 16'(e.a_en));
      check("a_seg", 16'(a_seg), 16'(e.a_seg));
      check("a_onehot", 16'($countones(~a_en)), 16'd1);
      check("b_match", 16'(b_match), 16'(e.b_m));
      check("b_count", b_cnt, e.b_c);
      check("c_match", 16'(c_match), 16'(e.c_m));
      check("c_count", c_cnt, e.c_c);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] pat4;
    bit         b;
    int         j;
    pat4 = 4'b1011;
    model_reset();
    @(posedge clk); #1;

    // Reset state
    cycle(0, 0, 0, 0);
    check("rst_enable", 16'(a_en), 16'h000e);
    check("rst_seg", 16'(a_seg), 16'h0040);
    check("rst_count", a_cnt, 16'h0000);
    check("rst_match", 16'(a_match), 16'h0000);

    // Overlap vs non-overlap on 1,0,1,1,0,1,1
    foreach (pat4[i]) cycle(pat4[i], 1, 0, 1);
    cycle(0, 1, 0, 1); cycle(1, 1, 0, 1); cycle(1, 1, 0, 1);
    cycle(0, 0, 0, 1); cycle(0, 0, 0, 1);
    check("t1_count_overlap", a_cnt, 16'h0002);
    check("t2_count_nonoverlap", b_cnt, 16'h0001);
    check("t1_count_len1", c_cnt, 16'h0005);

    // Partial sequence discarded by reset
    cycle(0, 0, 0, 0);
    cycle(1, 1, 0, 1); cycle(0, 1, 0, 1); cycle(1, 1, 0, 1);
    cycle(0, 0, 0, 0);
    cycle(1, 1, 0, 1); cycle(0, 1, 0, 1); cycle(1, 1, 0, 1);
    check("t3_no_early_match", 16'(a_match), 16'h0000);
    cycle(1, 1, 0, 1);
    check("t3_match_4th", 16'(a_match), 16'h0001);
    cycle(0, 0, 0, 1); cycle(0, 0, 0, 1);
    check("t3_count", a_cnt, 16'h0001);

    // Clear wins over a simultaneous increment
    cycle(0, 0, 0, 0);
    cycle(1, 1, 0, 1); cycle(0, 1, 0, 1); cycle(1, 1, 0, 1); cycle(1, 1, 0, 1);
    check("t5_match_high", 16'(a_match), 16'h0001);
    cycle(0, 0, 1, 1);
    check("t5_clear_a", a_cnt, 16'h0000);
    check("t5_clear_c", c_cnt, 16'h0000);
    cycle(0, 0, 0, 1);
    check("t5_stays_clear", a_cnt, 16'h0000);

    // BCD wrap at 9999 with SEQ_LEN=1
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 9999; i++) cycle(1, 1, 0, 1);
    cycle(0, 0, 0, 1); cycle(0, 0, 0, 1);
    check("t4_count_9999", c_cnt, 16'h9999);
    cycle(1, 1, 0, 1);
    check("t4_match_at_wrap", 16'(c_match), 16'h0001);
    cycle(0, 0, 0, 1);
    check("t4_wrap_0000", c_cnt, 16'h0000);

    // Drive count to 1234 and let the display scan all digits
    cycle(0, 0, 0, 0);
    j = 0;
    while (ca + int'(ma) < 1234) begin
      b = (j < 4) ? pat4[3 - j] : (((j - 4) % 3) != 0);
      cycle(b, 1, 0, 1);
      j++;
    end
    cycle(0, 0, 0, 1); cycle(0, 0, 0, 1);
    check("t6_count_1234", a_cnt, 16'h1234);
    for (int i = 0; i < 40; i++) cycle(0, 0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 800; i++)
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 49) == 0), ($urandom_range(0, 99) != 0));
    cycle(0, 0, 0, 1); cycle(0, 0, 0, 1);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", 16'(sb.size()), 16'h0000);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
